mesi_isc_mbus_monitor: RTL and testbench
========================================

Name: mesi_isc_mbus_monitor

Overview:
Parametrised main-bus transaction monitor for the MESI ISC environment, generalised to CPU_COUNT ports. It detects each rising edge of a per-CPU main-bus acknowledge. On that edge it snapshots the port's command, address and all coherence-bus acks, tags the snapshot with a timestamp, and queues it in a FIFO. Records leave through a valid/ready interface to the scoreboard/coverage collector. Unlike the earlier monitor, simultaneous acks are arbitrated, backpressure is absorbed, and lost events are counted.

Parameters:
CPU_COUNT, 4, number of CPU ports (2..8)
ADDR_WIDTH, 32, main-bus address width
MBUS_CMD_WIDTH, 3, main-bus command width
FIFO_DEPTH, 8, record FIFO entries (power of two, >=2)
TS_WIDTH, 16, timestamp counter width
CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count_o

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
enable_i  in  1  capture enable
mbus_cmd_i  in  CPU_COUNT*MBUS_CMD_WIDTH  packed per-CPU commands, CPU n at [n*W +: W]
mbus_addr_i  in  CPU_COUNT*ADDR_WIDTH  packed per-CPU addresses
mbus_ack_i  in  CPU_COUNT  per-CPU main-bus ack
cbus_ack_i  in  CPU_COUNT  per-CPU coherence-bus ack
rec_valid_o  out  1  record available at FIFO head
rec_ready_i  in  1  consumer accepts head record
rec_cpu_id_o  out  $clog2(CPU_COUNT)  source CPU
rec_cmd_o  out  MBUS_CMD_WIDTH  captured command
rec_addr_o  out  ADDR_WIDTH  captured address
rec_cbus_ack_o  out  CPU_COUNT  cbus acks at capture
rec_ts_o  out  TS_WIDTH  capture timestamp
fifo_count_o  out  CNT_W  FIFO occupancy
drop_count_o  out  8  dropped events, saturating at 255
overflow_o  out  1  sticky, set on any drop

Behaviour:
- Reset (rst=1 at posedge):
  - all outputs 0; FIFO empty; timestamp=0; round-robin pointer=0; pending bits cleared.
  - ack_d loads mbus_ack_i, so an ack already high when reset is released is not treated as a rise.
  - Reset mid-operation discards all pending and queued records.
- Timestamp: free-running, +1 per cycle, wraps 2^TS_WIDTH-1 -> 0.
- Rise detect: rise[n] = mbus_ack_i[n] & ~ack_d[n]; ack_d <= mbus_ack_i every cycle.
- Capture (cycle t, rise[n]=1, enable_i=1):
  - if pending[n]=0: hold[n] <= {cmd[n], addr[n], cbus_ack_i, ts}; pending[n] <= 1.
  - if pending[n]=1: new event is dropped; drop_count_o += 1 (saturating); overflow_o <= 1.
- enable_i=0: rises are ignored and not counted. Existing pending entries and FIFO contents still drain.
- Arbiter:
  - each cycle, grant the first pending[n] searching from rr, wrapping modulo CPU_COUNT.
  - push hold[n] into the FIFO if fifo not full, or if full with a pop in the same cycle.
  - on push, clear pending[n] and set rr <= (n+1) mod CPU_COUNT.
  - no push: rr is unchanged.
  - at most one push per cycle.
- A port's pending bit, cleared at a given edge, may be re-set by a rise sampled at that same edge (no drop).
- FIFO:
  - show-ahead; rec_* reflect the head; rec_valid_o = (count != 0).
  - pop when rec_valid_o & rec_ready_i.
  - simultaneous push and pop leaves count unchanged.
  - pointers wrap modulo FIFO_DEPTH.
  - rec_* hold stable while rec_valid_o=1 and rec_ready_i=0.
- Latency: rise sampled at edge t → pending after t → pushed at t+1 if granted → rec_valid_o=1 after t+1, i.e. visible 2 cycles after the rise edge.
- Full FIFO: pending entries wait. Further rises on those ports are dropped as above. No record is ever overwritten.

Test Plan:
- Single event: reset, ack[2] rises with cmd=3'd2, addr=32'h0000_0040, cbus_ack=4'b0100 → exactly one record {id=2, cmd=2, addr=0x40, cbus_ack=0100}, rec_valid_o high 2 cycles after the rise, ts = counter value at the rise edge.
- Simultaneous rises: ack[3:0] rise together with rr=0 → records pop in order ids 0,1,2,3 on consecutive pushes; fifo_count_o reaches 4; drop_count_o=0.
- Fairness: with rr=2, ack[0] and ack[3] rise together → id 3 pushed first, then 0; rr ends at 1.
- Backpressure:
  - rec_ready_i=0; generate 8 events → fifo_count_o=8.
  - 9th event on port 1 stays pending; a 10th rise on port 1 → drop_count_o=1, overflow_o=1.
  - raise rec_ready_i → 9 records drained in order, none corrupted.
- Enable/wrap: enable_i=0 with ack[0] toggling → no records, drop_count_o=0. With TS_WIDTH=4, a capture at cycle 17 after reset → rec_ts_o=4'd1.
- Reset mid-operation:
  - assert rst with 3 records queued and 1 pending, while ack[1] is held high → all outputs 0.
  - after release, no record from ack[1] until it falls and rises again.

Source files
------------

// File: rtl/mesi_isc_mbus_monitor.sv
// MESI ISC main-bus monitor: captures mbus ack rises per CPU,
// arbitrates round-robin into a show-ahead record FIFO.
module mesi_isc_mbus_monitor #(
  parameter int CPU_COUNT      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int FIFO_DEPTH     = 8,
  parameter int TS_WIDTH       = 16,
  parameter int CNT_W          = $clog2(FIFO_DEPTH+1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable_i,
  input  logic [CPU_COUNT*MBUS_CMD_WIDTH-1:0] mbus_cmd_i,
  input  logic [CPU_COUNT*ADDR_WIDTH-1:0]     mbus_addr_i,
  input  logic [CPU_COUNT-1:0]                mbus_ack_i,
  input  logic [CPU_COUNT-1:0]                cbus_ack_i,
  output logic                                rec_valid_o,
  input  logic                                rec_ready_i,
  output logic [$clog2(CPU_COUNT)-1:0]        rec_cpu_id_o,
  output logic [MBUS_CMD_WIDTH-1:0]           rec_cmd_o,
  output logic [ADDR_WIDTH-1:0]               rec_addr_o,
  output logic [CPU_COUNT-1:0]                rec_cbus_ack_o,
  output logic [TS_WIDTH-1:0]                 rec_ts_o,
  output logic [CNT_W-1:0]                    fifo_count_o,
  output logic [7:0]                          drop_count_o,
  output logic                                overflow_o
);

  localparam int ID_W  = $clog2(CPU_COUNT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]           id;
    logic [MBUS_CMD_WIDTH-1:0] cmd;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [CPU_COUNT-1:0]      cbus;
    logic [TS_WIDTH-1:0]       ts;
  } rec_t;

  logic [TS_WIDTH-1:0]  ts_q;
  logic [CPU_COUNT-1:0] ack_q;
  logic [CPU_COUNT-1:0] pend_q;
  logic [ID_W-1:0]      rr_q;
  logic [PTR_W-1:0]     wr_q;
  logic [PTR_W-1:0]     rd_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [7:0]           drop_q;
  logic [7:0]           drop_d;
  logic                 ovf_q;
  rec_t                 hold_q [CPU_COUNT];
  rec_t                 mem_q  [FIFO_DEPTH];

  logic [CPU_COUNT-1:0] rise;
  logic [CPU_COUNT-1:0] cap;
  logic [CPU_COUNT-1:0] drop_ev;
  logic [CPU_COUNT-1:0] clr;
  logic                 gnt_vld;
  logic [ID_W-1:0]      gnt_id;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic [3:0]           ndrop;
  logic [8:0]           dsum;
  rec_t                 head;

  assign rise = mbus_ack_i & ~ack_q;
  assign full = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign rec_valid_o = (cnt_q != '0);
  assign pop = rec_valid_o & rec_ready_i;

  // Round-robin grant from rr_q; lowest offset wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = CPU_COUNT-1; k >= 0; k--) begin
      if (pend_q[(int'(rr_q) + k) % CPU_COUNT]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'((int'(rr_q) + k) % CPU_COUNT);
      end
    end
    push = gnt_vld & (~full | pop);
    clr = '0;
    clr[gnt_id] = push;
  end

  // A port freed this cycle may accept a new capture.
  always_comb begin
    cap     = rise & {CPU_COUNT{enable_i}} & (~pend_q | clr);
    drop_ev = rise & {CPU_COUNT{enable_i}} & pend_q & ~clr;
    ndrop   = '0;
    for (int n = 0; n < CPU_COUNT; n++) begin
      ndrop = ndrop + {3'b000, drop_ev[n]};
    end
    dsum   = {1'b0, drop_q} + {5'b00000, ndrop};
    drop_d = dsum[8] ? 8'hFF : dsum[7:0];
  end

  // Control state: timestamp, pending, pointers, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q  <= mbus_ack_i;
      ts_q   <= '0;
      pend_q <= '0;
      rr_q   <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ack_q  <= mbus_ack_i;
      ts_q   <= ts_q + 1'b1;
      pend_q <= (pend_q & ~clr) | cap;
      if (push) begin
        wr_q <= wr_q + 1'b1;
        rr_q <= (gnt_id == ID_W'(CPU_COUNT-1)) ? '0 : gnt_id + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q  <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      drop_q <= drop_d;
      if (|drop_ev) ovf_q <= 1'b1;
    end
  end

  // Per-port snapshot taken on an accepted rise.
  always_ff @(posedge clk) begin
    for (int n = 0; n < CPU_COUNT; n++) begin
      if (cap[n]) begin
        hold_q[n] <= '{
          id:   ID_W'(n),
          cmd:  mbus_cmd_i[n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH],
          addr: mbus_addr_i[n*ADDR_WIDTH +: ADDR_WIDTH],
          cbus: cbus_ack_i,
          ts:   ts_q
        };
      end
    end
  end

  // Record storage; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= hold_q[gnt_id];
  end

  assign head           = rec_valid_o ? mem_q[rd_q] : '0;
  assign rec_cpu_id_o   = head.id;
  assign rec_cmd_o      = head.cmd;
  assign rec_addr_o     = head.addr;
  assign rec_cbus_ack_o = head.cbus;
  assign rec_ts_o       = head.ts;
  assign fifo_count_o   = cnt_q;
  assign drop_count_o   = drop_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_mesi_isc_mbus_monitor.sv
// Bench for mesi_isc_mbus_monitor: vector table plus
// hand-written sequences, records checked via a scoreboard.
module tb_mesi_isc_mbus_monitor;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [11:0] mbus_cmd;
  logic [127:0] mbus_addr;
  logic [3:0]  mbus_ack;
  logic [3:0]  cbus_ack;
  logic        rec_valid;
  logic        rec_ready;
  logic [1:0]  rec_id;
  logic [2:0]  rec_cmd;
  logic [31:0] rec_addr;
  logic [3:0]  rec_cb;
  logic [3:0]  rec_ts;
  logic [3:0]  fcount;
  logic [7:0]  dcount;
  logic        ovf;

  mesi_isc_mbus_monitor #(
    .CPU_COUNT(4), .ADDR_WIDTH(32), .MBUS_CMD_WIDTH(3),
    .FIFO_DEPTH(8), .TS_WIDTH(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable),
    .mbus_cmd_i(mbus_cmd), .mbus_addr_i(mbus_addr),
    .mbus_ack_i(mbus_ack), .cbus_ack_i(cbus_ack),
    .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
    .rec_cpu_id_o(rec_id), .rec_cmd_o(rec_cmd),
    .rec_addr_o(rec_addr), .rec_cbus_ack_o(rec_cb),
    .rec_ts_o(rec_ts), .fifo_count_o(fcount),
    .drop_count_o(dcount), .overflow_o(ovf)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  cb;
    logic [3:0]  ts;
  } exp_t;

  typedef struct {
    int          cpu;
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  cb;
    logic [1:0]  e_id;
    logic [2:0]  e_cmd;
    logic [31:0] e_addr;
    logic [3:0]  e_cb;
  } vec_t;

  exp_t sb[$];
  vec_t vt[5];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: cycles since reset, truncated to 4 bits.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Scoreboard compare on every accepted record.
  always begin
    @(negedge clk);
    #2;
    if (!rst && rec_valid && rec_ready) begin
      exp_t got;
      got = {rec_id, rec_cmd, rec_addr, rec_cb, rec_ts};
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rec_unexpected: got %h, required none", got);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL rec: got %h, required %h", got, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic setp(input int n, input logic [2:0] c, input logic [31:0] a);
    mbus_cmd[n*3 +: 3]   = c;
    mbus_addr[n*32 +: 32] = a;
  endtask

  task automatic rise_on(input logic [3:0] m, input logic [3:0] cb);
    @(negedge clk);
    cbus_ack = cb;
    mbus_ack = mbus_ack | m;
  endtask

  task automatic fall_on(input logic [3:0] m);
    @(negedge clk);
    mbus_ack = mbus_ack & ~m;
  endtask

  task automatic exp(input int n);
    sb.push_back('{id: 2'(n), cmd: mbus_cmd[n*3 +: 3],
                   addr: mbus_addr[n*32 +: 32], cb: cbus_ack,
                   ts: 4'(cyc)});
  endtask

  task automatic ev(input int n, input logic [2:0] c,
                    input logic [31:0] a, input logic [3:0] cb);
    setp(n, c, a);
    rise_on(4'(1 << n), cb);
    exp(n);
    fall_on(4'(1 << n));
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while ((sb.size() != 0 || rec_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 64'(sb.size() != 0 || rec_valid), 64'd0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; rec_ready = 1'b0;
    mbus_ack = '0; cbus_ack = '0; mbus_cmd = '0; mbus_addr = '0;

    vt[0] = '{2, 3'd2, 32'h0000_0040, 4'b0100, 2'd2, 3'd2, 32'h0000_0040, 4'b0100};
    vt[1] = '{0, 3'd7, 32'hFFFF_FFFC, 4'b1111, 2'd0, 3'd7, 32'hFFFF_FFFC, 4'b1111};
    vt[2] = '{3, 3'd0, 32'h0000_0000, 4'b0000, 2'd3, 3'd0, 32'h0000_0000, 4'b0000};
    vt[3] = '{1, 3'd5, 32'hA5A5_5A5A, 4'b0010, 2'd1, 3'd5, 32'hA5A5_5A5A, 4'b0010};
    vt[4] = '{3, 3'd1, 32'h8000_0000, 4'b1000, 2'd3, 3'd1, 32'h8000_0000, 4'b1000};

    wait_cyc(2);
    chk("rst_valid", 64'(rec_valid), 0);
    chk("rst_count", 64'(fcount), 0);
    chk("rst_drop", 64'(dcount), 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_addr", 64'(rec_addr), 0);
    rst = 1'b0;
    rec_ready = 1'b1;

    // Table: single events with 2-cycle latency check.
    for (int i = 0; i < 5; i++) begin
      setp(vt[i].cpu, vt[i].cmd, vt[i].addr);
      rise_on(4'(1 << vt[i].cpu), vt[i].cb);
      sb.push_back('{id: vt[i].e_id, cmd: vt[i].e_cmd, addr: vt[i].e_addr,
                     cb: vt[i].e_cb, ts: 4'(cyc)});
      @(negedge clk);
      chk("lat_t0", 64'(rec_valid), 0);
      mbus_ack = '0;
      @(negedge clk);
      chk("lat_t1", 64'(rec_valid), 1);
      wait_drain("tbl_drain");
    end

    // Simultaneous rises with rr=0.
    do_reset();
    rec_ready = 1'b0;
    for (int n = 0; n < 4; n++) setp(n, 3'(n + 1), 32'h1000 + 32'(n));
    rise_on(4'b1111, 4'b1010);
    exp(0); exp(1); exp(2); exp(3);
    fall_on(4'b1111);
    wait_cyc(6);
    chk("sim_count", 64'(fcount), 4);
    chk("sim_drop", 64'(dcount), 0);
    rec_ready = 1'b1;
    wait_drain("sim_drain");

    // Fairness: event on port 1 leaves rr=2.
    ev(1, 3'd6, 32'h2000, 4'b0001);
    wait_drain("rr_setup");
    setp(0, 3'd3, 32'h3000);
    setp(3, 3'd4, 32'h3003);
    rise_on(4'b1001, 4'b0110);
    exp(3); exp(0);
    fall_on(4'b1001);
    wait_drain("rr_30");
    setp(1, 3'd2, 32'h4001);
    setp(2, 3'd5, 32'h4002);
    rise_on(4'b0110, 4'b1001);
    exp(1); exp(2);
    fall_on(4'b0110);
    wait_drain("rr_12");

    // Backpressure: fill, one pending, one dropped.
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      ev(i % 4, 3'(i), 32'h100 + 32'(i * 4), 4'(i));
    wait_cyc(2);
    chk("bp_full", 64'(fcount), 8);
    ev(1, 3'd7, 32'hDEAD_0009, 4'b1100);
    wait_cyc(3);
    chk("bp_still8", 64'(fcount), 8);
    chk("bp_nodrop", 64'(dcount), 0);
    setp(1, 3'd1, 32'hBAD0_000A);
    rise_on(4'b0010, 4'b0011);
    fall_on(4'b0010);
    wait_cyc(2);
    chk("bp_drop", 64'(dcount), 1);
    chk("bp_ovf", 64'(ovf), 1);
    chk("bp_count", 64'(fcount), 8);
    rec_ready = 1'b1;
    wait_drain("bp_drain");

    // Reset mid-operation with ack[1] held high.
    rec_ready = 1'b0;
    ev(0, 3'd1, 32'h500, 4'b0001);
    ev(2, 3'd2, 32'h502, 4'b0100);
    ev(3, 3'd3, 32'h503, 4'b1000);
    setp(1, 3'd4, 32'h501);
    rise_on(4'b0010, 4'b0010);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_valid", 64'(rec_valid), 0);
    chk("mid_count", 64'(fcount), 0);
    chk("mid_drop", 64'(dcount), 0);
    chk("mid_ovf", 64'(ovf), 0);
    chk("mid_rec", 64'({rec_id, rec_cmd, rec_cb, rec_ts}), 0);
    rst = 1'b0;
    rec_ready = 1'b1;
    wait_cyc(6);
    chk("mid_noack", 64'(fcount), 0);
    fall_on(4'b0010);
    ev(1, 3'd5, 32'h601, 4'b0010);
    wait_drain("mid_rerise");

    // Enable low: rises ignored, nothing counted.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rise_on(4'b0001, 4'b0001);
      fall_on(4'b0001);
    end
    wait_cyc(4);
    chk("en_count", 64'(fcount), 0);
    chk("en_valid", 64'(rec_valid), 0);
    chk("en_drop", 64'(dcount), 0);
    enable = 1'b1;

    // Timestamp wrap: capture 17 cycles after reset.
    do_reset();
    while (cyc < 17) @(negedge clk);
    ev(2, 3'd3, 32'h7000, 4'b0101);
    wait_drain("wrap_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
